// File: rtl/mem_trace_recorder_if.sv
// Handshake bundle between the CPU memory-request side, the trace recorder
// and the trace consumer. The recorder uses the slave view; whoever drives
// the CPU requests and consumes the trace uses the master view.
interface mem_trace_recorder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic [31:0] PC;
    logic        trace_valid;
    logic        trace_ready;
    logic [100:0] trace_data;

    modport slave (
        input  MemRead, MemWrite, Address, Write_data, Write_strb, PC,
        input  trace_ready,
        output trace_valid, trace_data
    );

    modport master (
        output MemRead, MemWrite, Address, Write_data, Write_strb, PC,
        output trace_ready,
        input  trace_valid, trace_data
    );
endinterface

// File: rtl/mem_trace_recorder.sv
// Memory-request trace recorder: edge-detects CPU memory requests, packs
// each into a 101-bit record and queues it in a first-word fall-through
// FIFO drained over valid/ready. Also watches for the benchmark-end store
// and latches sticky done/pass flags.
module mem_trace_recorder #(
    parameter int unsigned DEPTH        = 16,
    parameter logic [31:0] PASS_ADDR    = 32'h0000000C,
    parameter bit          RECORD_READS = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    mem_trace_recorder_if.slave     bus,
    output logic [$clog2(DEPTH):0]  trace_count,
    output logic [15:0]             drop_cnt,
    output logic                    overflow,
    output logic                    proto_err,
    output logic                    done,
    output logic                    pass
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic {ST_RUN, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic          memread_q, memread_d;
    logic          memwrite_q, memwrite_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    logic [100:0]  mem_q [DEPTH];

    logic          wr_ev;
    logic          rd_ev;
    logic          want_push;
    logic          push_ok;
    logic          drop;
    logic          pop;
    logic          fifo_valid;
    logic          fifo_full;
    logic [AW:0]   count;
    logic [100:0]  rec;

    // Event detection, record packing and FIFO bookkeeping.
    always_comb begin
        wr_ev = bus.MemWrite & ~memwrite_q;
        // A simultaneous read is suppressed so only the write is recorded.
        rd_ev = bus.MemRead & ~memread_q & RECORD_READS & ~bus.MemWrite;

        count      = wr_ptr_q - rd_ptr_q;
        fifo_valid = (count != '0);
        fifo_full  = (count == FULL_CNT);

        want_push = (state_q == ST_RUN) & (wr_ev | rd_ev);
        pop       = fifo_valid & bus.trace_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok   = want_push & (~fifo_full | pop);
        drop      = want_push & fifo_full & ~pop;

        if (wr_ev) begin
            rec = {1'b1, bus.Write_strb, bus.Address, bus.Write_data, bus.PC};
        end else begin
            rec = {1'b0, 4'h0, bus.Address, 32'h0, bus.PC};
        end
    end

    // Next-state values for all control registers.
    always_comb begin
        memread_d   = bus.MemRead;
        memwrite_d  = bus.MemWrite;
        wr_ptr_d    = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q | drop;
        proto_err_d = proto_err_q | (bus.MemRead & bus.MemWrite);
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        // The end store itself is still pushed; only later events are blocked.
        if ((state_q == ST_RUN) && wr_ev && (bus.Address == PASS_ADDR)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (bus.Write_data == 32'h0);
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drop_cnt_q  <= 16'h0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Record storage; contents are meaningless until a pointer covers them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec;
        end
    end

    assign bus.trace_valid = fifo_valid;
    assign bus.trace_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign trace_count     = count;
    assign drop_cnt        = drop_cnt_q;
    assign overflow        = overflow_q;
    assign proto_err       = proto_err_q;
    assign done            = done_q;
    assign pass            = pass_q;

endmodule

// File: tb/tb_mem_trace_recorder.sv
// Bench for mem_trace_recorder: a table of single-cycle vectors for the basic
// record/drain path, then hand-written sequences for overflow, full-with-pop,
// benchmark end, protocol error and mid-run reset.
module tb_mem_trace_recorder;

    logic        clk;
    logic        resetn;
    logic [4:0]  trace_count;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        proto_err;
    logic        done;
    logic        pass;

    int checks;
    int errors;

    mem_trace_recorder_if bus();

    mem_trace_recorder #(
        .DEPTH(16),
        .PASS_ADDR(32'h0000000C),
        .RECORD_READS(1'b1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .trace_count(trace_count),
        .drop_cnt(drop_cnt),
        .overflow(overflow),
        .proto_err(proto_err),
        .done(done),
        .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   strb;
        logic [31:0]  pc;
        logic         ready;
        logic         exp_valid;
        logic [4:0]   exp_count;
        logic [100:0] exp_head;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = 32'h0;
        bus.Write_data = 32'h0;
        bus.Write_strb = 4'h0;
        bus.PC         = 32'h0;
        bus.trace_ready = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic pulse_read(input logic [31:0] addr, input logic [31:0] pc);
        bus.MemRead = 1'b1;
        bus.Address = addr;
        bus.PC      = pc;
        step();
        bus.MemRead = 1'b0;
        step();
    endtask

    task automatic pulse_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [31:0] pc);
        bus.MemWrite   = 1'b1;
        bus.Address    = addr;
        bus.Write_data = data;
        bus.Write_strb = strb;
        bus.PC         = pc;
        step();
        bus.MemWrite = 1'b0;
        step();
    endtask

    initial begin
        logic [100:0] wr_rec;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        set_idle();

        wr_rec = {1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'hBFC00010};
        vecs[0] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'hBFC00010, 1'b0, 1'b1, 5'd1, wr_rec};
        vecs[1] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'hBFC00010, 1'b0, 1'b1, 5'd1, wr_rec};
        vecs[2] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'hBFC00010, 1'b0, 1'b1, 5'd1, wr_rec};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h1000, 1'b0, 1'b1, 5'd2, wr_rec};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 5'd1,
                    {1'b0, 4'h0, 32'h200, 32'h0, 32'h1000}};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 5'd0, 101'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 5'd0, 101'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h1004, 1'b0, 1'b1, 5'd1,
                    {1'b0, 4'h0, 32'h300, 32'h0, 32'h1004}};
        vecs[8] = '{1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h1004, 1'b1, 1'b0, 5'd0, 101'h0};

        // Reset state.
        step();
        step();
        resetn = 1'b1;
        chk("rst_valid", bus.trace_valid, 1'b0);
        chk("rst_count", trace_count, 5'd0);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_proto", proto_err, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);

        // Table-driven basic record / drain path.
        for (int i = 0; i < 9; i++) begin
            bus.MemRead     = vecs[i].rd;
            bus.MemWrite    = vecs[i].wr;
            bus.Address     = vecs[i].addr;
            bus.Write_data  = vecs[i].wdata;
            bus.Write_strb  = vecs[i].strb;
            bus.PC          = vecs[i].pc;
            bus.trace_ready = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_valid", i), bus.trace_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_count", i), trace_count, vecs[i].exp_count);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_head", i), bus.trace_data, vecs[i].exp_head);
            end
        end

        // Overflow: 20 reads into a 16-entry FIFO, then ordered drain.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            pulse_read(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4));
        end
        chk("ovf_count", trace_count, 5'd16);
        chk("ovf_drop", drop_cnt, 16'd4);
        chk("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_head", i), bus.trace_data,
                {1'b0, 4'h0, 32'h1000 + 32'(i * 4), 32'h0, 32'h2000 + 32'(i * 4)});
            bus.trace_ready = 1'b1;
            step();
        end
        bus.trace_ready = 1'b0;
        chk("drain_empty_count", trace_count, 5'd0);
        chk("drain_empty_valid", bus.trace_valid, 1'b0);

        // Full FIFO with a simultaneous pop and push.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pulse_read(32'h4000 + 32'(i * 4), 32'h5000);
        end
        chk("full_count", trace_count, 5'd16);
        bus.trace_ready = 1'b1;
        bus.MemWrite    = 1'b1;
        bus.Address     = 32'h500;
        bus.Write_data  = 32'h55;
        bus.Write_strb  = 4'hF;
        bus.PC          = 32'h3000;
        step();
        chk("fullpop_count", trace_count, 5'd16);
        chk("fullpop_drop", drop_cnt, 16'd0);
        chk("fullpop_overflow", overflow, 1'b0);
        bus.MemWrite = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        bus.trace_ready = 1'b0;
        chk("fullpop_tail_count", trace_count, 5'd1);
        chk("fullpop_tail_head", bus.trace_data, {1'b1, 4'hF, 32'h500, 32'h55, 32'h3000});

        // Benchmark end with zero data: pass.
        do_reset();
        pulse_write(32'h0C, 32'h0, 4'hF, 32'h600);
        chk("end0_done", done, 1'b1);
        chk("end0_pass", pass, 1'b1);
        chk("end0_count", trace_count, 5'd1);
        chk("end0_head", bus.trace_data, {1'b1, 4'hF, 32'h0C, 32'h0, 32'h600});
        pulse_write(32'h200, 32'h1234, 4'hF, 32'h604);
        pulse_read(32'h204, 32'h608);
        chk("end0_blocked_count", trace_count, 5'd1);
        chk("end0_done_sticky", done, 1'b1);

        // Benchmark end with non-zero data: fail verdict.
        do_reset();
        pulse_write(32'h0C, 32'h5, 4'hF, 32'h700);
        chk("end5_done", done, 1'b1);
        chk("end5_pass", pass, 1'b0);

        // Read and write together: protocol error, only the write recorded.
        do_reset();
        bus.MemRead    = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.Address    = 32'h40;
        bus.Write_data = 32'h77;
        bus.Write_strb = 4'h3;
        bus.PC         = 32'h800;
        step();
        set_idle();
        step();
        chk("proto_flag", proto_err, 1'b1);
        chk("proto_count", trace_count, 5'd1);
        chk("proto_head", bus.trace_data, {1'b1, 4'h3, 32'h40, 32'h77, 32'h800});
        chk("proto_done", done, 1'b0);

        // Reset mid-run with 5 entries queued and done set.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_read(32'h900 + 32'(i * 4), 32'hA00);
        end
        pulse_write(32'h0C, 32'h0, 4'hF, 32'hA10);
        chk("mid_pre_count", trace_count, 5'd5);
        chk("mid_pre_done", done, 1'b1);
        do_reset();
        chk("mid_valid", bus.trace_valid, 1'b0);
        chk("mid_count", trace_count, 5'd0);
        chk("mid_done", done, 1'b0);
        chk("mid_pass", pass, 1'b0);
        chk("mid_drop", drop_cnt, 16'd0);
        pulse_write(32'h100, 32'hCAFE, 4'h1, 32'hB00);
        chk("mid_rerecord_count", trace_count, 5'd1);
        chk("mid_rerecord_head", bus.trace_data, {1'b1, 4'h1, 32'h100, 32'hCAFE, 32'hB00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
